// File: rtl/mul_seq_pkg.sv
// Shared definitions for the shift-and-add multiply sequencer and the ALU opcodes
// that the CPU control unit also drives.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        SHH  = 2'd2,
        SHL  = 2'd3
    } mul_state_t;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_LSR = 4'd10;
    localparam logic [3:0] ALU_OP_NOP = 4'd15;

    localparam logic [2:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/mul_seq.sv
// 8x8 unsigned multiply sequencer borrowing the shared ALU for ADD and LSR steps.
// Optional MUL_SKIP_ZERO_EN skips the ADD step for multiplier bits that are zero.
module mul_seq
    import mul_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_op_a,
    input  logic [7:0]  i_op_b,
    output logic [3:0]  o_alu_sel,
    output logic [7:0]  o_alu_a,
    output logic [7:0]  o_alu_b,
    output logic        o_alu_cin,
    input  logic [7:0]  i_alu_result,
    input  logic        i_alu_c,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_product
);

    mul_state_t r_state;
    mul_state_t w_next;
    logic [7:0] r_mcand;
    logic [7:0] r_hi;
    logic [7:0] r_lo;
    logic       r_cbit;
    logic [2:0] r_cnt;
    logic       r_done;

    always_comb begin
        w_next    = r_state;
        o_alu_sel = ALU_OP_NOP;
        o_alu_a   = 8'd0;
        o_alu_b   = 8'd0;
        o_alu_cin = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
`ifdef MUL_SKIP_ZERO_EN
                    w_next = i_op_b[0] ? ADD : SHH;
`else
                    w_next = ADD;
`endif
                end
            end
            ADD: begin
                o_alu_sel = ALU_OP_ADD;
                o_alu_a   = r_hi;
                o_alu_b   = r_lo[0] ? r_mcand : 8'd0;
                w_next    = SHH;
            end
            SHH: begin
                o_alu_sel = ALU_OP_LSR;
                o_alu_a   = r_hi;
                o_alu_cin = r_cbit;
                w_next    = SHL;
            end
            SHL: begin
                o_alu_sel = ALU_OP_LSR;
                o_alu_a   = r_lo;
                o_alu_cin = r_cbit;
                if (r_cnt == LAST_BIT) begin
                    w_next = IDLE;
                end else begin
`ifdef MUL_SKIP_ZERO_EN
                    // The shifted LO coming back from the ALU holds the next multiplier bit
                    w_next = i_alu_result[0] ? ADD : SHH;
`else
                    w_next = ADD;
`endif
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_mcand <= 8'd0;
            r_hi    <= 8'd0;
            r_lo    <= 8'd0;
            r_cbit  <= 1'b0;
            r_cnt   <= 3'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mcand <= i_op_a;
                        r_hi    <= 8'd0;
                        r_lo    <= i_op_b;
                        r_cbit  <= 1'b0;
                        r_cnt   <= 3'd0;
                    end
                end
                ADD, SHH: begin
                    r_hi   <= i_alu_result;
                    r_cbit <= i_alu_c;
                end
                SHL: begin
                    // CBIT is cleared so a skipped ADD leaves a clean carry for SHH
                    r_lo   <= i_alu_result;
                    r_cbit <= 1'b0;
                    r_cnt  <= r_cnt + 3'd1;
                    if (r_cnt == LAST_BIT) begin
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (r_state != IDLE);
    assign o_done    = r_done;
    assign o_product = {r_hi, r_lo};

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: external ALU model, table vectors, random products, and
// hand-written START-hold and mid-run reset sequences.
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [7:0]  alu_result;
    logic        alu_c;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    mul_seq dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_op_a       (op_a),
        .i_op_b       (op_b),
        .o_alu_sel    (alu_sel),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_cin    (alu_cin),
        .i_alu_result (alu_result),
        .i_alu_c      (alu_c),
        .o_busy       (busy),
        .o_done       (done),
        .o_product    (product)
    );

    always #5 clk = ~clk;

    // Combinational model of the shared ALU: ADD with carry, LSR shifting CIN into bit 7
    always_comb begin
        alu_result = 8'd0;
        alu_c      = 1'b0;
        case (alu_sel)
            4'd0:    {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            4'd10: begin
                alu_result = {alu_cin, alu_a[7:1]};
                alu_c      = alu_a[0];
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    function automatic int exp_latency(input logic [7:0] b);
`ifdef MUL_SKIP_ZERO_EN
        return 16 + $countones(b);
`else
        return 24;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for DONE counting BUSY cycles; current time is the negedge of the cycle after E0
    task automatic wait_done(input string name, input logic [15:0] exp_prod, input int exp_lat);
        int n = 0;
        int guard = 0;
        bit overlap = 0;
        while (!done && guard < 60) begin
            if (busy) n++;
            @(negedge clk);
            guard++;
        end
        if (!done) begin
            chk({name, "_timeout"}, 0, 1);
            return;
        end
        if (busy) overlap = 1;
        chk({name, "_busy_cycles"}, n, exp_lat);
        chk({name, "_product"}, product, exp_prod);
        chk({name, "_busy_with_done"}, {31'd0, overlap}, 0);
    endtask

    task automatic run_mul(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp_prod);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy_start"}, {31'd0, busy}, 1);
        wait_done(name, exp_prod, exp_latency(b));
        @(negedge clk);
        chk({name, "_done_pulse"}, {31'd0, done}, 0);
        chk({name, "_held"}, product, exp_prod);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h0D, 8'h0B, 16'h008F};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{8'hA5, 8'h00, 16'h0000};
        vecs[3] = '{8'h00, 8'h80, 16'h0000};
        vecs[4] = '{8'h80, 8'h01, 16'h0080};
        vecs[5] = '{8'h01, 8'hFF, 16'h00FF};

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = 8'h00;
        op_b  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_product", product, 0);
        chk("rst_alu_sel", alu_sel, 15);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        chk("rst_alu_cin", {31'd0, alu_cin}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);

        for (int i = 0; i < 6; i++) begin
            run_mul($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].prod);
            chk($sformatf("vec%0d_idle_sel", i), alu_sel, 15);
        end

        for (int i = 0; i < 25; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_mul($sformatf("rnd%0d", i), ra, rb, 16'(ra) * 16'(rb));
        end

        // START held high; operands change mid-run, restart in the DONE cycle
        op_a  = 8'h02;
        op_b  = 8'h03;
        start = 1'b1;
        @(negedge clk);
        chk("hold_busy_start", {31'd0, busy}, 1);
        repeat (4) @(negedge clk);
        op_a = 8'hFF;
        op_b = 8'hFF;
        wait_done("hold1", 16'h0006, exp_latency(8'h03) - 4);
        @(negedge clk);
        chk("hold_done_once", {31'd0, done}, 0);
        chk("hold_restart_busy", {31'd0, busy}, 1);
        start = 1'b0;
        wait_done("hold2", 16'hFE01, exp_latency(8'hFF));
        @(negedge clk);

        // Reset at BUSY cycle 10 aborts without DONE
        op_a  = 8'h12;
        op_b  = 8'h34;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_c10", {31'd0, busy}, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_product", product, 0);
        chk("abort_done", {31'd0, done}, 0);
        begin
            bit seen = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (done || busy) seen = 1;
            end
            chk("abort_no_done", {31'd0, seen}, 0);
        end
        run_mul("after_abort", 8'h12, 8'h34, 16'h03A8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
